bus_timer: RTL and testbench
============================

BUS_TIMER -- requirements
Module: bus_timer

Memory-mapped timer/interrupt responder on the CPU's single-cycle-ack data bus; drives the CPU interrupt-request input.

Interface
REQ-001 SHALL provide parameter: PRESCALE_INIT, 16'h0000, reset value of PRESCALE register.
REQ-002 SHALL provide port: clk_i  input  1  clock; all state on rising edge.
REQ-003 SHALL provide port: rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port: cyc_i  input  1  bus cycle request, held by initiator until ack_o.
REQ-005 SHALL provide port: we_i  input  1  1=write, 0=read; valid with cyc_i.
REQ-006 SHALL provide port: adr_i  input  32  byte address; only adr_i[4:2] decoded, others ignored.
REQ-007 SHALL provide port: sel_i  input  4  byte lane enables for writes; sel_i[0]=dat_i[7:0].
REQ-008 SHALL provide port: dat_i  input  32  write data.
REQ-009 SHALL provide port: dat_o  output  32  read data, valid only while ack_o=1.
REQ-010 SHALL provide port: ack_o  output  1  transfer complete, one-cycle pulse.
REQ-011 SHALL provide port: inter  output  3  interrupt request level to CPU, 0=none.

Function
REQ-012 SHALL decode adr_i[4:2]: 0 CTRL, 1 STATUS, 2 PRESCALE, 3 COUNT, 4-7 CMP0-CMP3.
REQ-013 CTRL SHALL hold [0]=enable, [7:4]=irq enable ch3..ch0 (bit 4+n = ch n); other bits read 0.
REQ-014 STATUS[3:0] SHALL hold pending flags; write-1-to-clear per bit; reads side-effect free.
REQ-015 PRESCALE[15:0] SHALL be reload value; bits 31:16 read 0, writes ignored.
REQ-016 Handshake FSM SHALL have states IDLE, ACK, WAIT.
REQ-017 IDLE: cyc_i=1 -> ACK; register read data captured into dat_o and write performed on this edge.
REQ-018 ACK: ack_o=1 for exactly one cycle; -> WAIT unconditionally.
REQ-019 WAIT: ack_o=0; -> IDLE when cyc_i=0; no new transaction accepted until cyc_i seen low.
REQ-020 Latency SHALL be 1 cycle: ack_o high in cycle after cyc_i first sampled high in IDLE.
REQ-021 dat_o SHALL be 0 whenever ack_o=0.
REQ-022 Writes SHALL update only byte lanes with sel_i bit set; sel_i=0 leaves register unchanged but still acks.
REQ-023 Prescaler SHALL count down from PRESCALE to 0 while CTRL.enable=1; at 0 generate tick and reload PRESCALE.
REQ-024 PRESCALE=0 SHALL produce a tick every enabled cycle.
REQ-025 Tick SHALL increment COUNT modulo 2^32 (0xFFFFFFFF -> 0).
REQ-026 On tick, if incremented value == CMPn, pending[n] SHALL be set on the same edge.
REQ-027 Bus write to COUNT SHALL override same-cycle tick and SHALL NOT set pending flags.
REQ-028 Same-edge set and W1C clear of pending[n]: set SHALL win.
REQ-029 CTRL.enable=0 SHALL freeze prescaler and COUNT; clearing enable SHALL NOT clear pending.
REQ-030 Writing PRESCALE SHALL reload the prescaler down-counter on the same edge.
REQ-031 inter SHALL be n+1 for highest n with pending[n]&ie[n], else 0; combinational from registers only.
REQ-032 Unused map entries: none exist; all 8 addresses decoded.

Reset
REQ-033 rst_i SHALL force immediately: FSM=IDLE, ack_o=0, dat_o=0, CTRL=0, STATUS=0, COUNT=0, prescaler=PRESCALE_INIT, PRESCALE=PRESCALE_INIT, CMP0-3=0xFFFFFFFF, inter=0.
REQ-034 Reset mid-transaction SHALL abort it with no register update; after release, held cyc_i SHALL start a new transaction.

Verification
REQ-035 Write CMP0=0x5, PRESCALE=0, CTRL=0x11 -> COUNT reaches 5 five ticks later, STATUS=0x1, inter=1.
REQ-036 Write STATUS=0x1 on match edge of CMP0 -> STATUS[0] remains 1; next write STATUS=0x1 -> STATUS=0, inter=0.
REQ-037 Write COUNT=0x12345678 with sel_i=4'b0010 from 0 -> COUNT=0x00005600; readback dat_o=0x00005600 with one ack pulse.
REQ-038 COUNT=0xFFFFFFFF, CMP2=0, CTRL=0x41 -> COUNT wraps to 0, STATUS=0x4, inter=3; pending ch0 and ch2 with both enabled -> inter=3.
REQ-039 PRESCALE=3, enable -> COUNT increments every 4 cycles; cyc_i held 3 cycles -> exactly one ack_o pulse.
REQ-040 Assert rst_i during ACK -> ack_o=0 immediately, all registers at reset values, inter=0.

Source files
------------

// File: rtl/bus_timer.sv
`default_nettype none
// ============================================================================
// Module      : bus_timer
// Description : Memory-mapped prescaled timer with four compare channels and
//               a prioritised interrupt level, on a single-cycle-ack bus.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_timer #(
  parameter logic [15:0] PRESCALE_INIT = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic [2:0]  inter
);

  localparam logic [2:0] c_a_ctrl   = 3'd0;
  localparam logic [2:0] c_a_status = 3'd1;
  localparam logic [2:0] c_a_presc  = 3'd2;
  localparam logic [2:0] c_a_count  = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        w_ack, w_acc, w_wr;
  logic [2:0]  w_reg;
  logic [31:0] w_rdata;
  logic [31:0] r_dat;

  logic        r_en;
  logic [3:0]  r_ie;
  logic [3:0]  r_pending;
  logic [15:0] r_prescale;
  logic [15:0] r_pcnt;
  logic [31:0] r_count;
  logic [31:0] r_cmp [4];

  logic        w_tick;
  logic [31:0] w_count_inc;
  logic [3:0]  w_set, w_clr, w_irq;
  logic        w_wr_ctrl, w_wr_status, w_wr_presc, w_wr_count;
  logic [15:0] w_prescale_new;
  logic        w_unused;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return res;
  endfunction

  // Handshake: one ack per cycle request; cyc_i must drop before the next one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack       = 1'b0;
    case (r_state)
      ST_IDLE: if (cyc_i) w_state_nxt = ST_ACK;
      ST_ACK: begin
        w_ack       = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: if (!cyc_i) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign ack_o    = w_ack;
  assign dat_o    = r_dat;
  assign w_acc    = (r_state == ST_IDLE) && cyc_i;
  assign w_wr     = w_acc && we_i;
  assign w_reg    = adr_i[4:2];
  assign w_unused = ^{adr_i[31:5], adr_i[1:0]};

  assign w_wr_ctrl   = w_wr && (w_reg == c_a_ctrl);
  assign w_wr_status = w_wr && (w_reg == c_a_status);
  assign w_wr_presc  = w_wr && (w_reg == c_a_presc);
  assign w_wr_count  = w_wr && (w_reg == c_a_count);

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      c_a_ctrl:   w_rdata = {24'h0, r_ie, 3'b000, r_en};
      c_a_status: w_rdata = {28'h0, r_pending};
      c_a_presc:  w_rdata = {16'h0, r_prescale};
      c_a_count:  w_rdata = r_count;
      default:    w_rdata = r_cmp[w_reg[1:0]];
    endcase
  end

  // Read data lives only for the ack cycle, so it is zero otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      r_dat <= '0;
    else if (w_acc) r_dat <= w_rdata;
    else            r_dat <= '0;
  end

  assign w_prescale_new = {sel_i[1] ? dat_i[15:8] : r_prescale[15:8],
                           sel_i[0] ? dat_i[7:0]  : r_prescale[7:0]};
  assign w_tick         = r_en && (r_pcnt == 16'h0);
  assign w_count_inc    = r_count + 32'd1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_en       <= 1'b0;
      r_ie       <= 4'h0;
      r_prescale <= PRESCALE_INIT;
      r_pcnt     <= PRESCALE_INIT;
      r_count    <= '0;
      r_pending  <= 4'h0;
      for (int i = 0; i < 4; i++) r_cmp[i] <= 32'hFFFF_FFFF;
    end else begin
      if (w_wr_ctrl && sel_i[0]) begin
        r_en <= dat_i[0];
        r_ie <= dat_i[7:4];
      end
      if (w_wr_presc) begin
        r_prescale <= w_prescale_new;
        r_pcnt     <= w_prescale_new;
      end else if (r_en) begin
        r_pcnt <= (r_pcnt == 16'h0) ? r_prescale : r_pcnt - 16'd1;
      end
      // A bus write to COUNT takes precedence over a coincident tick.
      if (w_wr_count)  r_count <= f_merge(r_count, dat_i, sel_i);
      else if (w_tick) r_count <= w_count_inc;
      r_pending <= w_set | (r_pending & ~w_clr);
      for (int i = 0; i < 4; i++)
        if (w_wr && w_reg[2] && (w_reg[1:0] == 2'(i)))
          r_cmp[i] <= f_merge(r_cmp[i], dat_i, sel_i);
    end
  end

  for (genvar n = 0; n < 4; n++) begin : g_ch
    assign w_set[n] = w_tick && !w_wr_count && (w_count_inc == r_cmp[n]);
    assign w_clr[n] = w_wr_status && sel_i[0] && dat_i[n];
  end

  assign w_irq = r_pending & r_ie;

  always_comb begin
    inter = 3'd0;
    if      (w_irq[3]) inter = 3'd4;
    else if (w_irq[2]) inter = 3'd3;
    else if (w_irq[1]) inter = 3'd2;
    else if (w_irq[0]) inter = 3'd1;
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_timer
// Description : Directed, table-driven self-checking bench for bus_timer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_timer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cyc_i = 1'b0;
  logic        we_i  = 1'b0;
  logic [31:0] adr_i = '0;
  logic [3:0]  sel_i = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic        ack_o;
  logic [2:0]  inter;

  int tests = 0;
  int failures = 0;

  bus_timer #(.PRESCALE_INIT(16'h0000)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .we_i(we_i), .adr_i(adr_i),
    .sel_i(sel_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .inter(inter)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Read data must be zero outside the ack cycle.
  always @(negedge clk_i) begin
    if (!ack_o) begin
      tests++;
      if (dat_o !== 32'h0) begin
        failures++;
        $display("FAIL dat_idle: got 0x%08h expected 0x00000000", dat_o);
      end
    end
  end

  task automatic bus(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                     input logic [31:0] dat, output logic [31:0] rd);
    int n_ack;
    bit done;
    n_ack = 0;
    done  = 0;
    rd    = '0;
    @(negedge clk_i);
    cyc_i = 1'b1; we_i = we; adr_i = adr; sel_i = sel; dat_i = dat;
    for (int i = 0; i < 8 && !done; i++) begin
      @(posedge clk_i); #1;
      if (ack_o) begin
        done = 1;
        n_ack++;
        rd = dat_o;
      end
    end
    cyc_i = 1'b0; we_i = 1'b0;
    if (!done) check("bus_timeout", 32'h0, 32'h1);
    repeat (2) begin
      @(posedge clk_i); #1;
      if (ack_o) n_ack++;
    end
    check("ack_pulse", 32'(n_ack), 32'h1);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] d;
    bus(1'b1, adr, 4'hF, dat, d);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    bus(1'b0, adr, 4'h0, 32'h0, d);
    check(name, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    int n;

    vecs[0]  = '{1'b0, 32'h00, 4'h0, 32'h0,          32'h0,          "rst_ctrl"};
    vecs[1]  = '{1'b0, 32'h04, 4'h0, 32'h0,          32'h0,          "rst_status"};
    vecs[2]  = '{1'b0, 32'h08, 4'h0, 32'h0,          32'h0,          "rst_presc"};
    vecs[3]  = '{1'b0, 32'h0C, 4'h0, 32'h0,          32'h0,          "rst_count"};
    vecs[4]  = '{1'b0, 32'h10, 4'h0, 32'h0,          32'hFFFF_FFFF,  "rst_cmp0"};
    vecs[5]  = '{1'b0, 32'h1C, 4'h0, 32'h0,          32'hFFFF_FFFF,  "rst_cmp3"};
    vecs[6]  = '{1'b1, 32'h00, 4'hF, 32'hFFFF_FFFE,  32'h0,          "w_ctrl"};
    vecs[7]  = '{1'b0, 32'h00, 4'h0, 32'h0,          32'h0000_00F0,  "ctrl_mask"};
    vecs[8]  = '{1'b1, 32'h00, 4'hF, 32'h0,          32'h0,          "w_ctrl0"};
    vecs[9]  = '{1'b1, 32'h08, 4'hF, 32'hABCD_1234,  32'h0,          "w_presc"};
    vecs[10] = '{1'b0, 32'h08, 4'h0, 32'h0,          32'h0000_1234,  "presc_hi0"};
    vecs[11] = '{1'b1, 32'h08, 4'h2, 32'h0000_FF00,  32'h0,          "w_presc_b1"};
    vecs[12] = '{1'b0, 32'h08, 4'h0, 32'h0,          32'h0000_FF34,  "presc_lane"};
    vecs[13] = '{1'b1, 32'h08, 4'hF, 32'h0,          32'h0,          "w_presc0"};
    vecs[14] = '{1'b1, 32'h0C, 4'h2, 32'h1234_5678,  32'h0,          "w_count_b1"};
    vecs[15] = '{1'b0, 32'h0C, 4'h0, 32'h0,          32'h0000_5600,  "count_lane"};
    vecs[16] = '{1'b1, 32'h14, 4'h5, 32'hAABB_CCDD,  32'h0,          "w_cmp1"};
    vecs[17] = '{1'b0, 32'h14, 4'h0, 32'h0,          32'hFFBB_FFDD,  "cmp1_lane"};
    vecs[18] = '{1'b1, 32'h18, 4'h0, 32'h0,          32'h0,          "w_cmp2_sel0"};
    vecs[19] = '{1'b0, 32'h18, 4'h0, 32'h0,          32'hFFFF_FFFF,  "cmp2_sel0"};
    vecs[20] = '{1'b0, 32'hFFFF_FF2C, 4'h0, 32'h0,   32'h0000_5600,  "count_alias"};
    vecs[21] = '{1'b1, 32'h04, 4'hF, 32'hF,          32'h0,          "w_status"};
    vecs[22] = '{1'b0, 32'h04, 4'h0, 32'h0,          32'h0,          "status_idle"};
    vecs[23] = '{1'b0, 32'h20, 4'h0, 32'h0,          32'h0,          "ctrl_alias"};

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ack", 32'(ack_o), 32'h0);
    check("rst_inter", 32'(inter), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 24; i++) begin
      bus(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, d);
      if (!vecs[i].we) check(vecs[i].name, d, vecs[i].exp);
    end

    // Count to CMP0=5 with PRESCALE=0; CTRL write edge is W, task returns at W+2
    wr(32'h0C, 32'h0);
    wr(32'h10, 32'h5);
    wr(32'h08, 32'h0);
    wr(32'h00, 32'h11);
    repeat (2) @(posedge clk_i);
    #1 check("cmp0_before", 32'(inter), 32'h0);
    @(posedge clk_i);
    #1 check("cmp0_match", 32'(inter), 32'h1);
    wr(32'h00, 32'h10);
    rd_chk("status_match", 32'h04, 32'h1);

    // W1C lands on the match edge: set wins
    wr(32'h04, 32'h1);
    wr(32'h0C, 32'h0);
    wr(32'h10, 32'h3);
    wr(32'h00, 32'h11);
    wr(32'h04, 32'h1);
    check("set_wins_inter", 32'(inter), 32'h1);
    wr(32'h00, 32'h10);
    rd_chk("set_wins_status", 32'h04, 32'h1);
    wr(32'h04, 32'h1);
    rd_chk("w1c_status", 32'h04, 32'h0);
    check("w1c_inter", 32'(inter), 32'h0);

    // COUNT write overrides tick and sets nothing
    wr(32'h10, 32'h100);
    wr(32'h00, 32'h11);
    wr(32'h0C, 32'h100);
    wr(32'h00, 32'h10);
    rd_chk("count_override", 32'h0C, 32'h103);
    check("override_nopend", 32'(inter), 32'h0);

    // Wrap 0xFFFFFFFF -> 0 matches CMP2
    wr(32'h0C, 32'hFFFF_FFFF);
    wr(32'h18, 32'h0);
    wr(32'h00, 32'h41);
    check("wrap_inter", 32'(inter), 32'h3);
    wr(32'h00, 32'h40);
    rd_chk("wrap_status", 32'h04, 32'h4);
    wr(32'h10, 32'h2);
    wr(32'h0C, 32'h1);
    wr(32'h00, 32'h51);
    check("prio_ch2_ch0", 32'(inter), 32'h3);
    wr(32'h00, 32'h50);
    rd_chk("both_status", 32'h04, 32'h5);
    wr(32'h00, 32'h10);
    check("prio_ie0_only", 32'(inter), 32'h1);

    // PRESCALE=3: a tick every 4 enabled cycles
    wr(32'h04, 32'hF);
    wr(32'h0C, 32'h0);
    wr(32'h10, 32'h1);
    wr(32'h14, 32'h2);
    wr(32'h08, 32'h3);
    wr(32'h00, 32'h31);
    @(posedge clk_i);
    #1 check("presc_t3", 32'(inter), 32'h0);
    @(posedge clk_i);
    #1 check("presc_t4", 32'(inter), 32'h1);
    repeat (3) @(posedge clk_i);
    #1 check("presc_t7", 32'(inter), 32'h1);
    @(posedge clk_i);
    #1 check("presc_t8", 32'(inter), 32'h2);

    // cyc_i held for 3 cycles yields one ack
    n = 0;
    @(negedge clk_i);
    cyc_i = 1'b1; we_i = 1'b0; adr_i = 32'h0C;
    repeat (3) begin
      @(posedge clk_i); #1;
      if (ack_o) n++;
    end
    cyc_i = 1'b0;
    repeat (3) begin
      @(posedge clk_i); #1;
      if (ack_o) n++;
    end
    check("hold_one_ack", 32'(n), 32'h1);

    // Reset during ACK, then a held cyc_i starts a fresh transaction
    @(negedge clk_i);
    cyc_i = 1'b1; we_i = 1'b0; adr_i = 32'h10;
    @(posedge clk_i);
    #1 check("pre_rst_ack", 32'(ack_o), 32'h1);
    rst_i = 1'b1;
    #1;
    check("rst_ack_low", 32'(ack_o), 32'h0);
    check("rst_dat_low", dat_o, 32'h0);
    check("rst_inter_low", 32'(inter), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("post_rst_ack", 32'(ack_o), 32'h1);
    check("post_rst_cmp0", dat_o, 32'hFFFF_FFFF);
    cyc_i = 1'b0;
    repeat (2) @(posedge clk_i);
    rd_chk("post_rst_ctrl", 32'h00, 32'h0);
    rd_chk("post_rst_count", 32'h0C, 32'h0);
    rd_chk("post_rst_presc", 32'h08, 32'h0);
    rd_chk("post_rst_cmp1", 32'h14, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
`default_nettype wire
